// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: dispatcher state encoding and command-entry layout {mem, lane, len, we, tag, idx}
package dma_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_NEXT       = 3'd4
  } state_t;
  function automatic int off_tag(input int iw);
    return iw;
  endfunction
  function automatic int off_we(input int iw, input int tw);
    return iw + tw;
  endfunction
  function automatic int off_len(input int iw, input int tw);
    return iw + tw + 1;
  endfunction
  function automatic int off_lane(input int iw, input int tw, input int lw);
    return iw + tw + 1 + lw;
  endfunction
  function automatic int off_mem(input int iw, input int tw, input int lw, input int aw);
    return iw + tw + 1 + lw + aw;
  endfunction
  function automatic int entry_w(input int iw, input int tw, input int lw, input int aw, input int dw);
    return iw + tw + 1 + lw + aw + dw;
  endfunction
endpackage

// File: rtl/dma_cmd_fifo.sv
// dma_cmd_fifo: synchronous command queue; push when full and pop when empty are ignored
module dma_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count != CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dma_sched.sv
// dma_sched: round-robin command arbiter, command FIFO and chunking dispatcher for the lane DMA engine
module dma_sched
  import dma_sched_pkg::*;
#(
  parameter int NUMREQ = 2,
  parameter int DMEM_ADDRWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int LEN_WIDTH = 16,
  parameter int TAGWIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CHUNK_BYTES = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMREQ-1:0]              req_valid,
  output logic [NUMREQ-1:0]              req_ready,
  input  logic [NUMREQ*DMEM_ADDRWIDTH-1:0] req_mem_addr,
  input  logic [NUMREQ*ADDRWIDTH-1:0]    req_lane_addr,
  input  logic [NUMREQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUMREQ-1:0]              req_we,
  input  logic [NUMREQ*TAGWIDTH-1:0]     req_tag,
  output logic                           dma_en,
  output logic [DMEM_ADDRWIDTH-1:0]      dma_mem_addr,
  output logic [ADDRWIDTH-1:0]           dma_lane_addr,
  output logic [7:0]                     dma_num_bytes,
  output logic                           dma_we,
  input  logic                           dma_busy,
  output logic                           done_valid,
  output logic [$clog2(NUMREQ)-1:0]      done_req,
  output logic [TAGWIDTH-1:0]            done_tag,
  output logic                           sched_busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  localparam int IW = $clog2(NUMREQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = entry_w(IW, TAGWIDTH, LEN_WIDTH, ADDRWIDTH, DMEM_ADDRWIDTH);
  localparam int O_TAG = off_tag(IW);
  localparam int O_WE = off_we(IW, TAGWIDTH);
  localparam int O_LEN = off_len(IW, TAGWIDTH);
  localparam int O_LANE = off_lane(IW, TAGWIDTH, LEN_WIDTH);
  localparam int O_MEM = off_mem(IW, TAGWIDTH, LEN_WIDTH, ADDRWIDTH);
  state_t state;
  logic [IW-1:0] rr, gidx;
  logic found, push, pop;
  logic [EW-1:0] din, head;
  logic [DMEM_ADDRWIDTH-1:0] cur_mem, h_mem;
  logic [ADDRWIDTH-1:0] cur_lane, h_lane;
  logic [LEN_WIDTH-1:0] remaining, h_len;
  logic [TAGWIDTH-1:0] h_tag;
  logic [IW-1:0] h_idx;
  logic h_we;
  function automatic logic [7:0] chunk_of(input logic [LEN_WIDTH-1:0] r);
    return (r < LEN_WIDTH'(CHUNK_BYTES)) ? r[7:0] : 8'(CHUNK_BYTES);
  endfunction
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUMREQ; i++)
      if (!found && req_valid[(int'(rr) + i) % NUMREQ]) begin
        found = 1'b1;
        gidx = IW'((int'(rr) + i) % NUMREQ);
      end
    req_ready = (found && reset && fifo_count < CW'(FIFO_DEPTH)) ? NUMREQ'(1) << gidx : '0;
  end
  assign push = |req_ready;
  assign din = {req_mem_addr[gidx*DMEM_ADDRWIDTH +: DMEM_ADDRWIDTH], req_lane_addr[gidx*ADDRWIDTH +: ADDRWIDTH],
                req_len[gidx*LEN_WIDTH +: LEN_WIDTH], req_we[gidx], req_tag[gidx*TAGWIDTH +: TAGWIDTH], gidx};
  assign h_mem = head[O_MEM +: DMEM_ADDRWIDTH];
  assign h_lane = head[O_LANE +: ADDRWIDTH];
  assign h_len = head[O_LEN +: LEN_WIDTH];
  assign h_we = head[O_WE];
  assign h_tag = head[O_TAG +: TAGWIDTH];
  assign h_idx = head[IW-1:0];
  assign pop = state == S_NEXT && remaining == '0;
  assign sched_busy = fifo_count != '0 || state != S_IDLE;
  dma_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .head(head), .count(fifo_count)
  );
  always_ff @(posedge clk)
    if (!reset) rr <= '0;
    else if (push) rr <= (gidx == IW'(NUMREQ - 1)) ? '0 : gidx + 1'b1;
  // dma_en and done_valid are registered, so they are raised on the transition into ISSUE / NEXT
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      dma_en <= 1'b0;
      dma_mem_addr <= '0;
      dma_lane_addr <= '0;
      dma_num_bytes <= '0;
      dma_we <= 1'b0;
      done_valid <= 1'b0;
      done_req <= '0;
      done_tag <= '0;
      cur_mem <= '0;
      cur_lane <= '0;
      remaining <= '0;
    end else begin
      dma_en <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        S_IDLE: if (fifo_count != '0) begin
          cur_mem <= h_mem;
          cur_lane <= h_lane;
          remaining <= h_len;
          dma_mem_addr <= h_mem;
          dma_lane_addr <= h_lane;
          dma_num_bytes <= chunk_of(h_len);
          dma_we <= h_we;
          dma_en <= h_len != '0;
          done_valid <= h_len == '0;
          done_req <= h_idx;
          done_tag <= h_tag;
          state <= (h_len == '0) ? S_NEXT : S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT_START;
        S_WAIT_START: if (dma_busy) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!dma_busy) begin
          remaining <= remaining - LEN_WIDTH'(dma_num_bytes);
          cur_mem <= cur_mem + DMEM_ADDRWIDTH'(dma_num_bytes);
          cur_lane <= cur_lane + ADDRWIDTH'(dma_num_bytes);
          done_valid <= remaining == LEN_WIDTH'(dma_num_bytes);
          done_req <= h_idx;
          done_tag <= h_tag;
          state <= S_NEXT;
        end
        S_NEXT: if (remaining != '0) begin
          dma_en <= 1'b1;
          dma_mem_addr <= cur_mem;
          dma_lane_addr <= cur_lane;
          dma_num_bytes <= chunk_of(remaining);
          state <= S_ISSUE;
        end else state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_sched.sv
// tb_dma_sched: directed commands with a scoreboard of expected engine chunks and completions
module tb_dma_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req_valid = '0, req_ready, req_we = '0;
  logic [63:0] req_mem_addr = '0;
  logic [15:0] req_lane_addr = '0;
  logic [31:0] req_len = '0;
  logic [7:0] req_tag = '0;
  logic dma_en, dma_we, done_valid, sched_busy, done_req;
  logic dma_busy = 1'b0;
  logic [31:0] dma_mem_addr;
  logic [7:0] dma_lane_addr, dma_num_bytes;
  logic [3:0] done_tag;
  logic [2:0] fifo_count;
  logic hold = 1'b0;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] mem; logic [7:0] lane; logic [7:0] nb; logic we;} dma_t;
  typedef struct {logic r; logic [3:0] tag;} done_t;
  dma_t exp_dma[$];
  done_t exp_done[$];
  dma_t de;
  done_t oe;
  dma_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mem_addr(req_mem_addr), .req_lane_addr(req_lane_addr), .req_len(req_len),
    .req_we(req_we), .req_tag(req_tag), .dma_en(dma_en), .dma_mem_addr(dma_mem_addr),
    .dma_lane_addr(dma_lane_addr), .dma_num_bytes(dma_num_bytes), .dma_we(dma_we),
    .dma_busy(dma_busy), .done_valid(done_valid), .done_req(done_req), .done_tag(done_tag),
    .sched_busy(sched_busy), .fifo_count(fifo_count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void exp_chunk(input logic [31:0] mem, input logic [7:0] lane, input logic [7:0] nb, input logic we);
    exp_dma.push_back('{mem, lane, nb, we});
  endfunction
  function automatic void exp_fin(input logic r, input logic [3:0] tag);
    exp_done.push_back('{r, tag});
  endfunction
  always @(negedge clk)
    if (reset) begin
      if (dma_en) begin
        if (exp_dma.size() == 0) chk("dma_en_unexpected", dma_en, 0);
        else begin
          de = exp_dma.pop_front();
          chk("dma_mem_addr", dma_mem_addr, de.mem);
          chk("dma_lane_addr", dma_lane_addr, de.lane);
          chk("dma_num_bytes", dma_num_bytes, de.nb);
          chk("dma_we", dma_we, de.we);
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) chk("done_valid_unexpected", done_valid, 0);
        else begin
          oe = exp_done.pop_front();
          chk("done_req", done_req, oe.r);
          chk("done_tag", done_tag, oe.tag);
        end
      end
    end
  initial forever begin
    @(negedge clk);
    if (dma_en && reset) begin
      repeat (2) @(negedge clk);
      dma_busy = 1'b1;
      repeat (3) @(negedge clk);
      while (hold) @(negedge clk);
      dma_busy = 1'b0;
    end
  end
  task automatic drive(input int r, input logic [31:0] mem, input logic [7:0] lane, input logic [15:0] len, input logic we, input logic [3:0] tag);
    req_valid[r] = 1'b1;
    req_mem_addr[r*32 +: 32] = mem;
    req_lane_addr[r*8 +: 8] = lane;
    req_len[r*16 +: 16] = len;
    req_we[r] = we;
    req_tag[r*4 +: 4] = tag;
  endtask
  task automatic send(input int r, input logic [31:0] mem, input logic [7:0] lane, input logic [15:0] len, input logic we, input logic [3:0] tag);
    int n = 0;
    @(negedge clk);
    drive(r, mem, lane, len, we, tag);
    #1;
    while (!req_ready[r] && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("accept_r%0d", r), req_ready, 2'b01 << r);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_dma.size() != 0 || exp_done.size() != 0 || sched_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    chk("idle_fifo_count", fifo_count, 0);
  endtask
  task automatic chk_reset();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dma_en", dma_en, 0);
    chk("rst_dma_mem_addr", dma_mem_addr, 0);
    chk("rst_dma_lane_addr", dma_lane_addr, 0);
    chk("rst_dma_num_bytes", dma_num_bytes, 0);
    chk("rst_dma_we", dma_we, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_req", done_req, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_sched_busy", sched_busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    reset = 1'b1;
    // single load
    exp_chunk(32'h1000, 8'h10, 8'd64, 1'b0);
    exp_fin(1'b0, 4'd3);
    send(0, 32'h1000, 8'h10, 16'd64, 1'b0, 4'd3);
    drain();
    // chunked store with lane wrap
    exp_chunk(32'h2000, 8'hF0, 8'd128, 1'b1);
    exp_chunk(32'h2080, 8'h70, 8'd128, 1'b1);
    exp_chunk(32'h2100, 8'hF0, 8'd44, 1'b1);
    exp_fin(1'b1, 4'd5);
    send(1, 32'h2000, 8'hF0, 16'd300, 1'b1, 4'd5);
    drain();
    // both requesters valid: grants alternate 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      exp_chunk(32'h3000, 8'h20, 8'd8, 1'b0);
      exp_chunk(32'h4000, 8'h40, 8'd16, 1'b1);
      exp_fin(1'b0, 4'd1);
      exp_fin(1'b1, 4'd2);
    end
    @(negedge clk);
    drive(0, 32'h3000, 8'h20, 16'd8, 1'b0, 4'd1);
    drive(1, 32'h4000, 8'h40, 16'd16, 1'b1, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant_%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    chk("rr_full_count", fifo_count, 4);
    drain();
    // backpressure with the engine held busy
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_chunk(32'h5000 + 32'(k) * 32'h100, 8'(k * 8), 8'd4, 1'b0);
      exp_fin(1'b0, 4'(6 + k));
    end
    for (int k = 0; k < 4; k++) send(0, 32'h5000 + 32'(k) * 32'h100, 8'(k * 8), 16'd4, 1'b0, 4'(6 + k));
    @(negedge clk);
    chk("bp_count_full", fifo_count, 4);
    chk("bp_sched_busy", sched_busy, 1);
    drive(0, 32'h5400, 8'd32, 16'd4, 1'b0, 4'd10);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bp_ready_low", req_ready, 0);
      @(negedge clk);
    end
    hold = 1'b0;
    n = 0;
    #1;
    while (!req_ready[0] && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp_accept_after_pop", req_ready, 2'b01);
    chk("bp_count_at_accept", fifo_count, 3);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
    // zero length completes without touching the engine
    exp_fin(1'b1, 4'd9);
    send(1, 32'h6000, 8'h00, 16'd0, 1'b0, 4'd9);
    drain();
    // reset while waiting on the engine with two more commands queued
    hold = 1'b1;
    exp_chunk(32'h7000, 8'h30, 8'd64, 1'b0);
    send(0, 32'h7000, 8'h30, 16'd64, 1'b0, 4'd11);
    send(1, 32'h7100, 8'h40, 16'd8, 1'b1, 4'd12);
    send(0, 32'h7200, 8'h50, 16'd8, 1'b0, 4'd13);
    n = 0;
    while (!dma_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("mid_busy_seen", dma_busy, 1);
    chk("mid_count", fifo_count, 3);
    reset = 1'b0;
    exp_dma.delete();
    exp_done.delete();
    @(negedge clk);
    chk_reset();
    reset = 1'b1;
    hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_idle", sched_busy, 0);
    chk("queues_empty", 64'(exp_dma.size() + exp_done.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
